// File: rtl/i2c_register_slave.sv
// I2C target exposing an 8-bit register pointer with write strobes and read requests.
// The pointer auto-increments after each data byte and wraps from 8'hFF to 8'h00.
module i2c_register_slave #(
   parameter logic [6:0] slaveAddress = 7'h39,
   parameter int         syncStages   = 2
) (
   input  logic       clock50M,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] regAddr,
   output logic [7:0] regWrData,
   output logic       regWrEn,
   output logic       regRdEn,
   input  logic [7:0] regRdData,
   output logic       busy
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_REG       = 4'd3;
   localparam logic [3:0] S_REG_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RDATA_ACK = 4'd8;
   localparam logic [3:0] S_IGNORE    = 4'd9;

   logic [syncStages-1:0] r_scl_sync;
   logic [syncStages-1:0] r_sda_sync;
   logic                  r_scl_d;
   logic                  r_sda_d;
   logic [3:0]            r_state;
   logic [3:0]            r_bit_cnt;
   logic [7:0]            r_shift;
   logic                  r_rw;
   logic                  r_ack;
   logic                  r_rd_pend;
   logic                  r_sda_low;

   logic w_scl;
   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges.
   always_ff @(posedge clock50M) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync[0] <= scl;
         r_sda_sync[0] <= sda;
         for (int i = 1; i < syncStages; i++) begin
            r_scl_sync[i] <= r_scl_sync[i-1];
            r_sda_sync[i] <= r_sda_sync[i-1];
         end
         r_scl_d <= r_scl_sync[syncStages-1];
         r_sda_d <= r_sda_sync[syncStages-1];
      end
   end

   assign w_scl      = r_scl_sync[syncStages-1];
   assign w_sda      = r_sda_sync[syncStages-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
   assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

   assign sda  = r_sda_low ? 1'b0 : 1'bz;
   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clock50M) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'h00;
         r_rw      <= 1'b0;
         r_ack     <= 1'b1;
         r_rd_pend <= 1'b0;
         r_sda_low <= 1'b0;
         regAddr   <= 8'h00;
         regWrData <= 8'h00;
         regWrEn   <= 1'b0;
         regRdEn   <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so any set below lasts exactly one clock.
         regWrEn   <= 1'b0;
         regRdEn   <= 1'b0;
         r_rd_pend <= regRdEn;
         if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_low <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_sda_low <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_REG, S_WDATA: begin
                  if (w_scl_rise) begin
                     r_shift   <= {r_shift[6:0], w_sda};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     r_bit_cnt <= 4'd0;
                     r_sda_low <= 1'b1;
                     if (r_state == S_ADDR) begin
                        r_rw <= r_shift[0];
                        if (r_shift[7:1] == slaveAddress) begin
                           r_state <= S_ADDR_ACK;
                        end else begin
                           r_state   <= S_IGNORE;
                           r_sda_low <= 1'b0;
                        end
                     end else if (r_state == S_REG) begin
                        regAddr <= r_shift;
                        r_state <= S_REG_ACK;
                     end else begin
                        regWrData <= r_shift;
                        regWrEn   <= 1'b1;
                        r_state   <= S_WDATA_ACK;
                     end
                  end
               end
               S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_low <= 1'b0;
                     r_bit_cnt <= 4'd0;
                     if (r_state == S_ADDR_ACK) begin
                        r_state <= r_rw ? S_RDATA : S_REG;
                        regRdEn <= r_rw;
                     end else begin
                        r_state <= S_WDATA;
                        if (r_state == S_WDATA_ACK) regAddr <= regAddr + 8'd1;
                     end
                  end
               end
               S_RDATA: begin
                  // Returned data arrives one cycle after the request; load it and present the MSB.
                  if (r_rd_pend) begin
                     r_shift   <= regRdData;
                     r_sda_low <= ~regRdData[7];
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= 4'd0;
                        r_sda_low <= 1'b0;
                        r_state   <= S_RDATA_ACK;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_sda_low <= ~r_shift[6];
                     end
                  end
               end
               S_RDATA_ACK: begin
                  if (w_scl_rise) begin
                     r_ack <= w_sda;
                  end else if (w_scl_fall) begin
                     if (!r_ack) begin
                        regAddr <= regAddr + 8'd1;
                        regRdEn <= 1'b1;
                        r_state <= S_RDATA;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_register_slave.sv
// Bench for i2c_register_slave: a bit-banged I2C master plus a strobe scoreboard.
module tb_i2c_register_slave;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda_low = 1'b0;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] reg_addr;
   logic [7:0] reg_wr_data;
   logic       reg_wr_en;
   logic       reg_rd_en;
   logic       busy;
   wire        sda_w;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   logic watch_nodrive = 1'b0;
   logic dut_drove = 1'b0;

   pullup (sda_w);
   assign sda_w = m_sda_low ? 1'b0 : 1'bz;

   always #10 clk = ~clk;

   i2c_register_slave #(.slaveAddress(7'h39), .syncStages(2)) dut (
      .clock50M (clk),
      .reset    (reset),
      .scl      (m_scl),
      .sda      (sda_w),
      .regAddr  (reg_addr),
      .regWrData(reg_wr_data),
      .regWrEn  (reg_wr_en),
      .regRdEn  (reg_rd_en),
      .regRdData(rd_data),
      .busy     (busy)
   );

   // Register file stand-in: contents of address A read back as A+1.
   always @(posedge clk) if (reg_rd_en) rd_data <= reg_addr + 8'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      ev_t e;
      if (reg_wr_en || reg_rd_en) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h, expected none",
                     reg_wr_en, reg_rd_en, reg_addr);
         end else begin
            e = exp_q.pop_front();
            check("strobe_exclusive", {31'd0, reg_wr_en & reg_rd_en}, 0);
            check("strobe_kind_wr", {31'd0, reg_wr_en}, {31'd0, e.wr});
            check("strobe_addr", {24'd0, reg_addr}, {24'd0, e.addr});
            if (e.wr) check("strobe_wdata", {24'd0, reg_wr_data}, {24'd0, e.data});
         end
      end
      if (watch_nodrive && !m_sda_low && sda_w === 1'b0) dut_drove <= 1'b1;
   end

   task automatic wait_q();
      repeat (5) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; wait_q();
      m_scl = 1'b1;     wait_q();
      m_sda_low = 1'b1; wait_q();
      m_scl = 1'b0;     wait_q();
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; wait_q();
      m_scl = 1'b1;     wait_q();
      m_sda_low = 1'b0; wait_q();
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b; wait_q();
      m_scl = 1'b1;   wait_q(); wait_q();
      m_scl = 1'b0;   wait_q();
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0; wait_q();
      m_scl = 1'b1;     wait_q();
      b = sda_w;        wait_q();
      m_scl = 1'b0;     wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic ack_bit);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(bit_v);
         b[i] = bit_v;
      end
      send_bit(ack_bit);
   endtask

   task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] data);
      ev_t e;
      e.wr = wr; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      logic       bit_v;

      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_regaddr", {24'd0, reg_addr}, 32'h00);
      check("rst_wrdata", {24'd0, reg_wr_data}, 32'h00);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_sda", {31'd0, sda_w}, 1);
      check("rst_wren", {31'd0, reg_wr_en}, 0);
      check("rst_rden", {31'd0, reg_rd_en}, 0);

      // Burst write: 0x10 <= A5, 0x11 <= 5A
      push(1'b1, 8'h10, 8'hA5);
      push(1'b1, 8'h11, 8'h5A);
      i2c_start();
      check("wr_busy", {31'd0, busy}, 1);
      send_byte(8'h72, ack); check("wr_ack_addr", {31'd0, ack}, 0);
      send_byte(8'h10, ack); check("wr_ack_reg", {31'd0, ack}, 0);
      send_byte(8'hA5, ack); check("wr_ack_d0", {31'd0, ack}, 0);
      send_byte(8'h5A, ack); check("wr_ack_d1", {31'd0, ack}, 0);
      i2c_stop();
      wait_q();
      check("wr_final_addr", {24'd0, reg_addr}, 32'h12);
      check("wr_final_data", {24'd0, reg_wr_data}, 32'h5A);
      check("wr_busy_after", {31'd0, busy}, 0);

      // Read with repeated START: bytes 0x21, 0x22
      push(1'b0, 8'h20, 8'h00);
      push(1'b0, 8'h21, 8'h00);
      i2c_start();
      send_byte(8'h72, ack); check("rd_ack_addr", {31'd0, ack}, 0);
      send_byte(8'h20, ack); check("rd_ack_reg", {31'd0, ack}, 0);
      i2c_start();
      send_byte(8'h73, ack); check("rd_ack_addr_r", {31'd0, ack}, 0);
      recv_byte(rb, 1'b0); check("rd_byte0", {24'd0, rb}, 32'h21);
      recv_byte(rb, 1'b1); check("rd_byte1", {24'd0, rb}, 32'h22);
      i2c_stop();
      wait_q();
      check("rd_final_addr", {24'd0, reg_addr}, 32'h21);

      // Wrong address: no ACK, sda never pulled by the target
      dut_drove = 1'b0;
      watch_nodrive = 1'b1;
      i2c_start();
      send_byte(8'h74, ack); check("bad_nack_addr", {31'd0, ack}, 1);
      send_byte(8'h10, ack); check("bad_nack_reg", {31'd0, ack}, 1);
      i2c_stop();
      wait_q();
      watch_nodrive = 1'b0;
      check("bad_no_drive", {31'd0, dut_drove}, 0);
      check("bad_busy", {31'd0, busy}, 0);
      check("bad_addr_kept", {24'd0, reg_addr}, 32'h21);

      // Pointer wrap: 0xFF <= 11, 0x00 <= 22
      push(1'b1, 8'hFF, 8'h11);
      push(1'b1, 8'h00, 8'h22);
      i2c_start();
      send_byte(8'h72, ack); check("wrap_ack_addr", {31'd0, ack}, 0);
      send_byte(8'hFF, ack); check("wrap_ack_reg", {31'd0, ack}, 0);
      send_byte(8'h11, ack); check("wrap_ack_d0", {31'd0, ack}, 0);
      send_byte(8'h22, ack); check("wrap_ack_d1", {31'd0, ack}, 0);
      i2c_stop();
      wait_q();
      check("wrap_final_addr", {24'd0, reg_addr}, 32'h01);

      // STOP after 3 bits of a data byte
      i2c_start();
      send_byte(8'h72, ack);
      send_byte(8'h10, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      i2c_stop();
      wait_q();
      check("stopmid_busy", {31'd0, busy}, 0);
      check("stopmid_addr", {24'd0, reg_addr}, 32'h10);
      check("stopmid_wdata", {24'd0, reg_wr_data}, 32'h22);

      // Reset during 4th bit of a write data byte
      i2c_start();
      send_byte(8'h72, ack);
      send_byte(8'h30, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      m_sda_low = 1'b0; wait_q();
      m_scl = 1'b1; wait_q();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abortw_addr", {24'd0, reg_addr}, 32'h00);
      check("abortw_wdata", {24'd0, reg_wr_data}, 32'h00);
      check("abortw_busy", {31'd0, busy}, 0);
      m_scl = 1'b0; wait_q();
      reset = 1'b0; wait_q();
      // No START after reset: the target must stay silent
      send_byte(8'h72, ack); check("noStart_nack", {31'd0, ack}, 1);
      check("noStart_busy", {31'd0, busy}, 0);
      i2c_stop();
      wait_q();

      // Reset while the target is pulling sda low during a read bit
      push(1'b0, 8'h20, 8'h00);
      i2c_start();
      send_byte(8'h72, ack);
      send_byte(8'h20, ack);
      i2c_start();
      send_byte(8'h73, ack); check("abortr_ack", {31'd0, ack}, 0);
      rb = 8'h00;
      for (int i = 2; i >= 0; i--) begin
         recv_bit(bit_v);
         rb[i] = bit_v;
      end
      check("abortr_bits", {24'd0, rb}, 32'h01);
      m_sda_low = 1'b0; wait_q();
      m_scl = 1'b1; wait_q();
      check("abortr_driven", {31'd0, sda_w}, 0);
      reset = 1'b1;
      @(negedge clk);
      check("abortr_released", {31'd0, sda_w}, 1);
      m_scl = 1'b0; wait_q();
      reset = 1'b0; wait_q();
      check("abortr_addr", {24'd0, reg_addr}, 32'h00);
      i2c_stop();
      wait_q();

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_register_slave.md
I2C_REGISTER_SLAVE -- requirements
Module: i2c_register_slave

Interface
REQ-001 SHALL have parameter slaveAddress, default 7'h39, 7-bit I2C target address.
REQ-002 SHALL have parameter syncStages, default 2, number of flops in the SCL and SDA synchronizers.
REQ-003 SHALL have port clock50M, input, 1, system clock at 50 MHz.
REQ-004 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port scl, input, 1, I2C clock driven by the master, up to 400 kHz.
REQ-006 SHALL have port sda, inout, 1, open-drain I2C data: drives 0 or high-Z, never 1.
REQ-007 SHALL have port regAddr, output, 8, current register pointer.
REQ-008 SHALL have port regWrData, output, 8, received data byte.
REQ-009 SHALL have port regWrEn, output, 1, one-cycle write strobe.
REQ-010 SHALL have port regRdEn, output, 1, one-cycle read request.
REQ-011 SHALL have port regRdData, input, 8, register contents, valid 1 cycle after regRdEn.
REQ-012 SHALL have port busy, output, 1, high from START until STOP or return to idle.

Function
REQ-013 SHALL pass scl and sda through syncStages flops, then detect rise and fall edges by comparing against one further delayed copy.
REQ-014 SHALL detect START (or repeated START) as synchronized sda falling while synchronized scl high, from any state.
REQ-015 SHALL detect STOP as synchronized sda rising while synchronized scl high, from any state, and enter IDLE on the next cycle.
REQ-016 SHALL sample sda on each scl rising edge and change its sda drive only on the cycle after an scl falling edge.
REQ-017 SHALL use states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 IDLE/any state + START -> ADDR. Bit counter is cleared.
REQ-019 ADDR: SHALL shift in 8 bits MSB first. On the 8th scl fall: if bits[7:1]==slaveAddress -> ADDR_ACK, else -> IGNORE with sda released.
REQ-020 ADDR_ACK: SHALL drive sda low for one scl period, then go to REG (R/W=0) or RDATA (R/W=1).
REQ-021 REG: SHALL shift in 8 bits and load regAddr on the 8th scl fall, then go to REG_ACK (ACK driven), then WDATA.
REQ-022 WDATA: SHALL shift in 8 bits. On the 8th scl fall it SHALL load regWrData, pulse regWrEn for exactly 1 cycle with the current regAddr, and go to WDATA_ACK (ACK driven).
REQ-023 After the WDATA_ACK scl fall, regAddr SHALL increment, wrapping 8'hFF->8'h00, and the state SHALL return to WDATA.
REQ-024 On entry to RDATA, regRdEn SHALL pulse for 1 cycle; regRdData SHALL be captured into the shift register 2 cycles after the pulse, before the first bit is driven.
REQ-025 RDATA: SHALL drive the 8 bits MSB first by pulling sda low for 0 bits and releasing it for 1 bits, then release sda for RDATA_ACK.
REQ-026 RDATA_ACK: SHALL sample the master bit on scl rise. On ACK (0), regAddr increments with wrap and the state returns to RDATA, re-pulsing regRdEn. On NACK (1), the state goes to IGNORE.
REQ-027 IGNORE: SHALL keep sda released and ignore the bus until START or STOP.
REQ-028 regWrEn and regRdEn SHALL never be high in the same cycle and SHALL never pulse outside WDATA/RDATA handling.
REQ-029 A START received mid-byte SHALL abort the byte without a regWrEn pulse; regAddr is retained across a repeated START.
REQ-030 busy SHALL be high in every state except IDLE and IGNORE-after-STOP.

Reset
REQ-031 Reset SHALL put the block in IDLE with sda released, regAddr=8'h00, regWrData=8'h00, regWrEn=0, regRdEn=0, busy=0, synchronizer flops=1.
REQ-032 Reset asserted mid-transfer SHALL release sda on the next clock edge and discard the partial byte.
REQ-033 After reset deasserts, the block SHALL respond only after a fresh START.

Verification
REQ-034 Write: S, 0x72, 0x10, 0xA5, 0x5A, P -> ACK on all 4 bytes; regWrEn pulses at regAddr 0x10 (data 0xA5) and 0x11 (data 0x5A); final regAddr=0x12.
REQ-035 Read: S, 0x72, 0x20, Sr, 0x73, master ACK, master NACK, P, with regRdData=regAddr+1 -> bus bytes 0x21 then 0x22; two regRdEn pulses; final regAddr=0x21.
REQ-036 Wrong address: S, 0x74, 0x10, P -> no ACK (sda never driven), no strobes, busy=0 after STOP.
REQ-037 Wrap: write with register address 0xFF and 2 data bytes -> writes land at 0xFF then 0x00.
REQ-038 Abort: reset asserted during the 4th bit of a data byte -> sda released the next cycle, no regWrEn, regAddr=0x00.
REQ-039 STOP mid-byte: S, 0x72, 0x10, 3 bits, P -> no regWrEn, state IDLE, busy=0.
